// File: rtl/uart_csr_pkg.sv
// Shared definitions for the UART AXI4-Lite CSR block: register offsets,
// response codes, CONTROL/IRQ field positions and the CONTROL layout.
package uart_csr_pkg;

  localparam logic [7:0] OFF_CONTROL    = 8'h00;
  localparam logic [7:0] OFF_STATUS     = 8'h04;
  localparam logic [7:0] OFF_TX_DATA    = 8'h08;
  localparam logic [7:0] OFF_RX_DATA    = 8'h0C;
  localparam logic [7:0] OFF_BAUD_DIV   = 8'h10;
  localparam logic [7:0] OFF_IRQ_STATUS = 8'h14;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int CTRL_TX_EN_BIT     = 0;
  localparam int CTRL_RX_EN_BIT     = 1;
  localparam int CTRL_LOOPBACK_BIT  = 2;
  localparam int CTRL_IRQ_EN_LSB    = 4;
  localparam int CTRL_TX_THRESH_LSB = 8;
  localparam int CTRL_RX_THRESH_LSB = 16;

  localparam int IRQ_TX_LOW_BIT   = 0;
  localparam int IRQ_RX_AVAIL_BIT = 1;
  localparam int IRQ_OVERRUN_BIT  = 2;

  // Writable CONTROL bits; everything else reads back as zero.
  localparam logic [31:0] CTRL_WR_MASK =
      (32'h1  << CTRL_TX_EN_BIT)     | (32'h1  << CTRL_RX_EN_BIT) |
      (32'h1  << CTRL_LOOPBACK_BIT)  | (32'h7  << CTRL_IRQ_EN_LSB) |
      (32'hFF << CTRL_TX_THRESH_LSB) | (32'hFF << CTRL_RX_THRESH_LSB);

  typedef struct packed {
    logic [7:0] rsvd_hi;
    logic [7:0] rx_thresh;
    logic [7:0] tx_thresh;
    logic       rsvd7;
    logic [2:0] irq_en;
    logic       rsvd3;
    logic       loopback;
    logic       rx_en;
    logic       tx_en;
  } ctrl_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_slave_wr_ctrl.sv
// AXI4-Lite write-side controller: captures AW and W independently, issues a
// single commit strobe when both are present, and holds the B response.
module axil_slave_wr_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ADDR_W-1:0] awaddr_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        wstrb_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [1:0]        bresp_o,
  output logic              bvalid_o,
  input  logic              bready_i,
  output logic              commit_o,
  output logic [ADDR_W-1:0] commit_addr_o,
  output logic [31:0]       commit_data_o,
  output logic [3:0]        commit_strb_o,
  input  logic [1:0]        commit_resp_i
);

  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              aw_hs, w_hs, b_hs;

  // Valid/ready: a channel transfers in any cycle where both are high at the
  // clock edge; once valid is raised by the sender it is held until transfer.
  assign awready_o = !aw_held_q;
  assign wready_o  = !w_held_q;
  assign bvalid_o  = bvalid_q;
  assign bresp_o   = bresp_q;

  assign aw_hs = awvalid_i && !aw_held_q;
  assign w_hs  = wvalid_i && !w_held_q;
  assign b_hs  = bvalid_q && bready_i;

  // Held halves stay captured until B completes, so bvalid gates re-commit.
  assign commit_o      = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;
  assign commit_addr_o = aw_held_q ? awaddr_q : awaddr_i;
  assign commit_data_o = w_held_q ? wdata_q : wdata_i;
  assign commit_strb_o = w_held_q ? wstrb_q : wstrb_i;

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = awaddr_i;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = wdata_i;
      wstrb_d  = wstrb_i;
    end
    if (commit_o) begin
      bvalid_d = 1'b1;
      bresp_d  = commit_resp_i;
    end
    if (b_hs) begin
      bvalid_d  = 1'b0;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

endmodule

// File: rtl/uart_axil_csr_v2.sv
// UART register block on AXI4-Lite: CONTROL, STATUS, TX/RX data ports,
// baud divisor and level/overrun interrupts with a registered irq.
module uart_axil_csr_v2
  import uart_csr_pkg::*;
#(
  parameter int               ADDR_W    = 8,
  parameter int               LVL_W     = 5,
  parameter int               DIV_W     = 16,
  parameter logic [DIV_W-1:0] DIV_RESET = 16'd868
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  output logic              tx_fifo_wrvalid,
  output logic [7:0]        tx_fifo_wrdata,
  input  logic              tx_fifo_full,
  input  logic [LVL_W-1:0]  tx_fifo_level,
  output logic              rx_fifo_rdready,
  input  logic [7:0]        rx_fifo_rddata,
  input  logic              rx_fifo_empty,
  input  logic [LVL_W-1:0]  rx_fifo_level,
  input  logic              rx_overrun,
  output logic              ctrl_tx_en,
  output logic              ctrl_rx_en,
  output logic              ctrl_loopback,
  output logic [DIV_W-1:0]  baud_div,
  output logic              irq
);

  if (LVL_W > 8) begin : g_lvl_w_chk
    $error("LVL_W must not exceed 8");
  end
  if (DIV_W > 32) begin : g_div_w_chk
    $error("DIV_W must not exceed 32");
  end

  logic              wr_commit;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic [1:0]        wr_resp;

  ctrl_t             ctrl_q, ctrl_d;
  logic [DIV_W-1:0]  baud_q, baud_d;
  logic              ovr_q, ovr_d;
  logic              irq_q, irq_d;
  logic              tx_wrvalid_q, tx_wrvalid_d;
  logic [7:0]        tx_wrdata_q, tx_wrdata_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rx_pop_q, rx_pop_d;

  logic [31:0]       rd_data_c;
  logic [1:0]        rd_resp_c;
  logic              rd_pop_c;
  logic              ar_hs;
  logic [7:0]        tx_lvl8, rx_lvl8;
  logic              rx_lvl_max;
  logic [2:0]        irq_stat;

  axil_slave_wr_ctrl #(.ADDR_W(ADDR_W)) u_wr_ctrl (
    .aclk          (aclk),
    .areset        (areset),
    .awaddr_i      (awaddr),
    .awvalid_i     (awvalid),
    .awready_o     (awready),
    .wdata_i       (wdata),
    .wstrb_i       (wstrb),
    .wvalid_i      (wvalid),
    .wready_o      (wready),
    .bresp_o       (bresp),
    .bvalid_o      (bvalid),
    .bready_i      (bready),
    .commit_o      (wr_commit),
    .commit_addr_o (wr_addr),
    .commit_data_o (wr_data),
    .commit_strb_o (wr_strb),
    .commit_resp_i (wr_resp)
  );

  assign tx_lvl8    = 8'(tx_fifo_level);
  assign rx_lvl8    = 8'(rx_fifo_level);
  assign rx_lvl_max = (rx_fifo_level == {LVL_W{1'b1}});

  always_comb begin
    irq_stat                   = '0;
    irq_stat[IRQ_TX_LOW_BIT]   = (tx_lvl8 <= ctrl_q.tx_thresh);
    irq_stat[IRQ_RX_AVAIL_BIT] = (rx_lvl8 >= ctrl_q.rx_thresh) && !rx_fifo_empty;
    irq_stat[IRQ_OVERRUN_BIT]  = ovr_q;
  end

  // Write side effects and response, evaluated only in the commit cycle.
  always_comb begin
    ctrl_d       = ctrl_q;
    baud_d       = baud_q;
    ovr_d        = ovr_q;
    tx_wrvalid_d = 1'b0;
    tx_wrdata_d  = tx_wrdata_q;
    wr_resp      = RESP_OKAY;
    if (wr_commit) begin
      case (wr_addr)
        ADDR_W'(OFF_CONTROL):
          ctrl_d = ctrl_t'(apply_wstrb(ctrl_q, wr_data, wr_strb) & CTRL_WR_MASK);
        ADDR_W'(OFF_STATUS), ADDR_W'(OFF_RX_DATA): ;
        ADDR_W'(OFF_TX_DATA): begin
          if (tx_fifo_full) begin
            wr_resp = RESP_SLVERR;
          end else if (wr_strb[0]) begin
            tx_wrvalid_d = 1'b1;
            tx_wrdata_d  = wr_data[7:0];
          end
        end
        ADDR_W'(OFF_BAUD_DIV):
          baud_d = DIV_W'(apply_wstrb(32'(baud_q), wr_data, wr_strb));
        ADDR_W'(OFF_IRQ_STATUS):
          if (wr_strb[0] && wr_data[IRQ_OVERRUN_BIT]) ovr_d = 1'b0;
        default: wr_resp = RESP_DECERR;
      endcase
    end
    // A new overrun outranks a simultaneous W1C.
    if (rx_overrun) ovr_d = 1'b1;
    irq_d = |(irq_stat & ctrl_q.irq_en);
  end

  assign ar_hs = arvalid && !rvalid_q;

  always_comb begin
    rd_data_c = '0;
    rd_resp_c = RESP_OKAY;
    rd_pop_c  = 1'b0;
    case (araddr)
      ADDR_W'(OFF_CONTROL):  rd_data_c = ctrl_q;
      ADDR_W'(OFF_STATUS):
        rd_data_c = {8'h00, rx_lvl8, tx_lvl8, 4'h0,
                     rx_lvl_max, rx_fifo_empty, tx_fifo_full, (tx_lvl8 == 8'h00)};
      ADDR_W'(OFF_TX_DATA):  rd_data_c = '0;
      ADDR_W'(OFF_RX_DATA): begin
        if (rx_fifo_empty) begin
          rd_resp_c = RESP_SLVERR;
        end else begin
          rd_data_c = {24'h0, rx_fifo_rddata};
          rd_pop_c  = 1'b1;
        end
      end
      ADDR_W'(OFF_BAUD_DIV):   rd_data_c = 32'(baud_q);
      ADDR_W'(OFF_IRQ_STATUS): rd_data_c = 32'(irq_stat);
      default:                 rd_resp_c = RESP_DECERR;
    endcase

    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rx_pop_d = 1'b0;
    if (rvalid_q && rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data_c;
      rresp_d  = rd_resp_c;
      rx_pop_d = rd_pop_c;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ctrl_q       <= '0;
      baud_q       <= DIV_RESET;
      ovr_q        <= 1'b0;
      irq_q        <= 1'b0;
      tx_wrvalid_q <= 1'b0;
      tx_wrdata_q  <= 8'h00;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
      rx_pop_q     <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      baud_q       <= baud_d;
      ovr_q        <= ovr_d;
      irq_q        <= irq_d;
      tx_wrvalid_q <= tx_wrvalid_d;
      tx_wrdata_q  <= tx_wrdata_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      rx_pop_q     <= rx_pop_d;
    end
  end

  assign arready         = !rvalid_q;
  assign rvalid          = rvalid_q;
  assign rdata           = rdata_q;
  assign rresp           = rresp_q;
  assign tx_fifo_wrvalid = tx_wrvalid_q;
  assign tx_fifo_wrdata  = tx_wrdata_q;
  assign rx_fifo_rdready = rx_pop_q;
  assign ctrl_tx_en      = ctrl_q.tx_en;
  assign ctrl_rx_en      = ctrl_q.rx_en;
  assign ctrl_loopback   = ctrl_q.loopback;
  assign baud_div        = baud_q;
  assign irq             = irq_q;

endmodule

// File: tb/tb_uart_axil_csr_v2.sv
// Directed bench for uart_axil_csr_v2: AXI4-Lite reads/writes with
// hand-computed expectations, FIFO pulse counters and a final report.
module tb_uart_axil_csr_v2;

  logic        aclk;
  logic        areset;
  logic [7:0]  awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [7:0]  araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic        tx_fifo_wrvalid;
  logic [7:0]  tx_fifo_wrdata;
  logic        tx_fifo_full;
  logic [4:0]  tx_fifo_level;
  logic        rx_fifo_rdready;
  logic [7:0]  rx_fifo_rddata;
  logic        rx_fifo_empty;
  logic [4:0]  rx_fifo_level;
  logic        rx_overrun;
  logic        ctrl_tx_en, ctrl_rx_en, ctrl_loopback;
  logic [15:0] baud_div;
  logic        irq;

  int          n_checks = 0;
  int          n_errors = 0;
  int          tx_push_cnt = 0;
  logic [7:0]  tx_last = 8'h00;
  int          rx_pop_cnt = 0;

  uart_axil_csr_v2 dut (
    .aclk            (aclk),
    .areset          (areset),
    .awaddr          (awaddr),
    .awvalid         (awvalid),
    .awready         (awready),
    .wdata           (wdata),
    .wstrb           (wstrb),
    .wvalid          (wvalid),
    .wready          (wready),
    .bresp           (bresp),
    .bvalid          (bvalid),
    .bready          (bready),
    .araddr          (araddr),
    .arvalid         (arvalid),
    .arready         (arready),
    .rdata           (rdata),
    .rresp           (rresp),
    .rvalid          (rvalid),
    .rready          (rready),
    .tx_fifo_wrvalid (tx_fifo_wrvalid),
    .tx_fifo_wrdata  (tx_fifo_wrdata),
    .tx_fifo_full    (tx_fifo_full),
    .tx_fifo_level   (tx_fifo_level),
    .rx_fifo_rdready (rx_fifo_rdready),
    .rx_fifo_rddata  (rx_fifo_rddata),
    .rx_fifo_empty   (rx_fifo_empty),
    .rx_fifo_level   (rx_fifo_level),
    .rx_overrun      (rx_overrun),
    .ctrl_tx_en      (ctrl_tx_en),
    .ctrl_rx_en      (ctrl_rx_en),
    .ctrl_loopback   (ctrl_loopback),
    .baud_div        (baud_div),
    .irq             (irq)
  );

  // Clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // FIFO-side pulse monitors
  always @(posedge aclk) begin
    if (tx_fifo_wrvalid) begin
      tx_push_cnt++;
      tx_last = tx_fifo_wrdata;
    end
    if (rx_fifo_rdready) rx_pop_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_lead, input int b_delay, input bit ovr_at_commit,
                           output logic [1:0] resp);
    bit   aw_done, w_done, hs_aw, hs_w;
    int   k;
    logic [1:0] first_resp;
    aw_done = 0;
    w_done  = 0;
    k       = 0;
    awaddr  = a;
    wdata   = d;
    wstrb   = s;
    while ((!aw_done || !w_done) && k < 50) begin
      awvalid = !aw_done;
      wvalid  = !w_done && (k >= aw_lead);
      #1;
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      if (aw_done && !w_done) check("awready_low_held", {31'b0, awready}, 32'd0);
      if (ovr_at_commit && (aw_done || hs_aw) && (w_done || hs_w)) rx_overrun = 1'b1;
      @(negedge aclk);
      rx_overrun = 1'b0;
      aw_done = aw_done || hs_aw;
      w_done  = w_done || hs_w;
      k++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (k >= 50) check("aw_w_timeout", 32'd1, 32'd0);
    first_resp = bresp;
    for (int i = 0; i < b_delay; i++) begin
      check("bvalid_held", {31'b0, bvalid}, 32'd1);
      check("bresp_stable", {30'b0, bresp}, {30'b0, first_resp});
      @(negedge aclk);
    end
    bready = 1'b1;
    k = 0;
    while (!bvalid && k < 50) begin
      @(negedge aclk);
      k++;
    end
    if (k >= 50) check("b_timeout", 32'd1, 32'd0);
    resp = bresp;
    @(negedge aclk);
    bready = 1'b0;
    check("bvalid_drop", {31'b0, bvalid}, 32'd0);
    check("awready_back", {31'b0, awready}, 32'd1);
    check("wready_back", {31'b0, wready}, 32'd1);
  endtask

  task automatic axi_read(input logic [7:0] a, input int r_delay,
                          output logic [31:0] d, output logic [1:0] resp);
    araddr  = a;
    arvalid = 1'b1;
    #1;
    check("arready_idle", {31'b0, arready}, 32'd1);
    @(negedge aclk);
    arvalid = 1'b0;
    check("rvalid_rise", {31'b0, rvalid}, 32'd1);
    d    = rdata;
    resp = rresp;
    for (int i = 0; i < r_delay; i++) begin
      @(negedge aclk);
      check("rvalid_held", {31'b0, rvalid}, 32'd1);
      check("rdata_stable", rdata, d);
      check("arready_low", {31'b0, arready}, 32'd0);
    end
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
    check("rvalid_drop", {31'b0, rvalid}, 32'd0);
    check("arready_back", {31'b0, arready}, 32'd1);
  endtask

  logic [31:0] rd;
  logic [1:0]  rs;
  logic [1:0]  bs;
  int          cnt0;

  initial begin
    areset = 1'b1;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    tx_fifo_full = 0; tx_fifo_level = 5'd2;
    rx_fifo_rddata = 8'h00; rx_fifo_empty = 1; rx_fifo_level = 5'd0; rx_overrun = 0;

    #12;
    check("rst_awready", {31'b0, awready}, 32'd1);
    check("rst_wready", {31'b0, wready}, 32'd1);
    check("rst_arready", {31'b0, arready}, 32'd1);
    check("rst_bvalid", {31'b0, bvalid}, 32'd0);
    check("rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_baud", {16'b0, baud_div}, 32'd868);
    check("rst_ctrl", {29'b0, ctrl_loopback, ctrl_rx_en, ctrl_tx_en}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("rst_txvalid", {31'b0, tx_fifo_wrvalid}, 32'd0);
    check("rst_rdready", {31'b0, rx_fifo_rdready}, 32'd0);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);

    axi_read(8'h10, 0, rd, rs);
    check("baud_rd_data", rd, 32'h0000_0364);
    check("baud_rd_resp", {30'b0, rs}, 32'd0);
    axi_read(8'h00, 0, rd, rs);
    check("ctrl_rd_data", rd, 32'h0);

    // TX push with AW leading W by three cycles and a slow B consumer
    cnt0 = tx_push_cnt;
    axi_write(8'h08, 32'h0000_0041, 4'b0001, 3, 4, 0, bs);
    check("tx_resp", {30'b0, bs}, 32'd0);
    check("tx_push_cnt", tx_push_cnt - cnt0, 32'd1);
    check("tx_push_data", {24'b0, tx_last}, 32'h41);

    tx_fifo_full = 1'b1;
    cnt0 = tx_push_cnt;
    axi_write(8'h08, 32'h0000_0042, 4'b0001, 0, 0, 0, bs);
    check("tx_full_resp", {30'b0, bs}, 32'd2);
    check("tx_full_nopush", tx_push_cnt - cnt0, 32'd0);
    tx_fifo_full = 1'b0;

    cnt0 = tx_push_cnt;
    axi_write(8'h08, 32'h0000_0043, 4'b1110, 0, 0, 0, bs);
    check("tx_nostrb_resp", {30'b0, bs}, 32'd0);
    check("tx_nostrb_nopush", tx_push_cnt - cnt0, 32'd0);

    cnt0 = rx_pop_cnt;
    axi_read(8'h0C, 0, rd, rs);
    check("rx_empty_resp", {30'b0, rs}, 32'd2);
    check("rx_empty_data", rd, 32'h0);
    check("rx_empty_nopop", rx_pop_cnt - cnt0, 32'd0);

    rx_fifo_rddata = 8'h5A; rx_fifo_empty = 1'b0; rx_fifo_level = 5'd3;
    cnt0 = rx_pop_cnt;
    axi_read(8'h0C, 5, rd, rs);
    check("rx_data", rd, 32'h0000_005A);
    check("rx_resp", {30'b0, rs}, 32'd0);
    check("rx_one_pop", rx_pop_cnt - cnt0, 32'd1);

    axi_read(8'h04, 0, rd, rs);
    check("status_mid", rd, 32'h0003_0200);
    rx_fifo_level = 5'd31;
    axi_read(8'h04, 0, rd, rs);
    check("status_rx_full", rd, 32'h001F_0208);
    rx_fifo_level = 5'd3;
    axi_read(8'h08, 0, rd, rs);
    check("txdata_rd", rd, 32'h0);
    axi_write(8'h04, 32'hFFFF_FFFF, 4'b1111, 0, 0, 0, bs);
    check("status_wr_resp", {30'b0, bs}, 32'd0);

    // CONTROL with byte strobes; irq_en = overrun only
    axi_write(8'h00, 32'h0000_0047, 4'b1111, 0, 0, 0, bs);
    axi_write(8'h00, 32'hFFFF_FFFF, 4'b0010, 0, 1, 0, bs);
    axi_read(8'h00, 0, rd, rs);
    check("ctrl_strb", rd, 32'h0000_FF47);
    check("ctrl_outs", {29'b0, ctrl_loopback, ctrl_rx_en, ctrl_tx_en}, 32'd7);
    check("irq_idle", {31'b0, irq}, 32'd0);

    rx_overrun = 1'b1;
    @(negedge aclk);
    rx_overrun = 1'b0;
    @(negedge aclk);
    check("irq_ovr", {31'b0, irq}, 32'd1);
    axi_read(8'h14, 0, rd, rs);
    check("irqstat_ovr", rd, 32'h7);

    axi_write(8'h14, 32'h4, 4'b0001, 0, 0, 1, bs);
    axi_read(8'h14, 0, rd, rs);
    check("ovr_set_wins", rd, 32'h7);
    check("irq_still", {31'b0, irq}, 32'd1);

    axi_write(8'h14, 32'h4, 4'b0001, 0, 0, 0, bs);
    axi_read(8'h14, 0, rd, rs);
    check("ovr_cleared", rd, 32'h3);
    check("irq_cleared", {31'b0, irq}, 32'd0);

    // TX_LOW interrupt: threshold 0, level 2 -> inactive until level drops
    axi_write(8'h00, 32'h0003_0017, 4'b1111, 0, 0, 0, bs);
    check("irq_txlow_off", {31'b0, irq}, 32'd0);
    axi_read(8'h14, 0, rd, rs);
    check("rx_avail_at_thresh", rd, 32'h2);
    rx_fifo_level = 5'd2;
    axi_read(8'h14, 0, rd, rs);
    check("rx_avail_below", rd, 32'h0);
    tx_fifo_level = 5'd0;
    @(negedge aclk);
    check("irq_txlow_on", {31'b0, irq}, 32'd1);
    tx_fifo_level = 5'd2;

    axi_write(8'h10, 32'h1234_5678, 4'b0001, 0, 0, 0, bs);
    axi_read(8'h10, 0, rd, rs);
    check("baud_byte0", rd, 32'h0000_0378);
    axi_write(8'h10, 32'h1234_5678, 4'b1111, 1, 0, 0, bs);
    axi_read(8'h10, 0, rd, rs);
    check("baud_full", rd, 32'h0000_5678);
    check("baud_out", {16'b0, baud_div}, 32'h5678);

    axi_read(8'h18, 0, rd, rs);
    check("decerr_rd_resp", {30'b0, rs}, 32'd3);
    check("decerr_rd_data", rd, 32'h0);
    axi_write(8'h1C, 32'hFFFF_FFFF, 4'b1111, 0, 0, 0, bs);
    check("decerr_wr_resp", {30'b0, bs}, 32'd3);

    // Reset while a B response is pending
    awaddr = 8'h10; wdata = 32'h0000_1111; wstrb = 4'b1111;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("pend_bvalid", {31'b0, bvalid}, 32'd1);
    #2 areset = 1'b1;
    #1;
    check("midrst_bvalid", {31'b0, bvalid}, 32'd0);
    check("midrst_baud", {16'b0, baud_div}, 32'd868);
    check("midrst_awready", {31'b0, awready}, 32'd1);
    check("midrst_irq", {31'b0, irq}, 32'd0);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    axi_read(8'h10, 0, rd, rs);
    check("post_rst_baud", rd, 32'h0000_0364);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
